// File: rtl/sda_gmem_axi_slave.sv
// AXI4 slave responder backed by a 32-bit word memory, used as the far end of the
// kernel gmem port. One outstanding write and one outstanding read, INCR bursts only.
module sda_gmem_axi_slave #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 1,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [1:0]            o_dbg_wstate,
    output logic [1:0]            o_dbg_rstate
);

    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    // Handshakes: a beat transfers on the rising clk edge where valid && ready are both high.
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    function automatic logic f_legal(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [2:0] size,
                                     input logic [1:0] burst);
        return (burst == 2'b01) && (size == 3'b010) &&
               (addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] == '0);
    endfunction

    // ---------------- write channel ----------------
    wstate_t                   r_wstate, w_wstate_nxt;
    logic [MEM_ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]                r_wlen, r_wcnt;
    logic [ID_WIDTH-1:0]       r_wid;
    logic                      r_wlegal;
    logic                      r_awready, r_wready, r_bvalid;
    logic [1:0]                r_bresp;
    logic [ID_WIDTH-1:0]       r_bid;

    logic w_aw_hs, w_w_hs, w_b_hs, w_wcnt_end, w_wburst_end;
    assign w_aw_hs      = s_axi_awvalid && r_awready;
    assign w_w_hs       = s_axi_wvalid && r_wready;
    assign w_b_hs       = r_bvalid && s_axi_bready;
    assign w_wcnt_end   = (r_wcnt == r_wlen);
    assign w_wburst_end = w_w_hs && (s_axi_wlast || w_wcnt_end);

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_wburst_end) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_wstate <= W_IDLE;
        else       r_wstate <= w_wstate_nxt;
    end

    // Ready/valid flags are registered from the next state so they are all low in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_bid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_wid     <= '0;
            r_wlegal  <= 1'b0;
        end else begin
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_waddr  <= s_axi_awaddr[MEM_ADDR_WIDTH+1:2];
                r_wlen   <= s_axi_awlen;
                r_wid    <= s_axi_awid;
                r_wlegal <= f_legal(s_axi_awaddr, s_axi_awsize, s_axi_awburst);
                r_wcnt   <= 8'd0;
            end
            if (w_w_hs) begin
                r_waddr <= r_waddr + 1'b1;
                r_wcnt  <= r_wcnt + 8'd1;
            end
            if (w_wburst_end) begin
                r_bid   <= r_wid;
                r_bresp <= (r_wlegal && (s_axi_wlast == w_wcnt_end)) ? 2'b00 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs && r_wlegal) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) r_mem[r_waddr][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t                   r_rstate, w_rstate_nxt;
    logic [MEM_ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]                r_rlen, r_rcnt;
    logic [ID_WIDTH-1:0]       r_arid;
    logic                      r_rlegal;
    logic                      r_arready, r_rvalid, r_rlast;
    logic [1:0]                r_rresp;
    logic [ID_WIDTH-1:0]       r_rid;
    logic [DATA_WIDTH-1:0]     r_rdata;

    logic w_ar_hs, w_r_hs;
    assign w_ar_hs = s_axi_arvalid && r_arready;
    assign w_r_hs  = r_rvalid && s_axi_rready;

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_FETCH;
            R_FETCH: w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs) w_rstate_nxt = r_rlast ? R_IDLE : R_FETCH;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rstate <= R_IDLE;
        else       r_rstate <= w_rstate_nxt;
    end

    // Memory is read only in R_FETCH, which keeps rdata stable under R backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_arid    <= '0;
            r_rlegal  <= 1'b0;
        end else begin
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_raddr  <= s_axi_araddr[MEM_ADDR_WIDTH+1:2];
                r_rlen   <= s_axi_arlen;
                r_arid   <= s_axi_arid;
                r_rlegal <= f_legal(s_axi_araddr, s_axi_arsize, s_axi_arburst);
                r_rcnt   <= 8'd0;
            end
            if (r_rstate == R_FETCH) begin
                r_rdata <= r_rlegal ? r_mem[r_raddr] : '0;
                r_rlast <= (r_rcnt == r_rlen);
                r_rid   <= r_arid;
                r_rresp <= r_rlegal ? 2'b00 : 2'b10;
            end
            if (w_r_hs) begin
                r_raddr <= r_raddr + 1'b1;
                r_rcnt  <= r_rcnt + 8'd1;
                r_rlast <= 1'b0;
            end
        end
    end

    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bid     = r_bid;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign o_dbg_wstate  = r_wstate;
    assign o_dbg_rstate  = r_rstate;

endmodule

// File: tb/tb_sda_gmem_axi_slave.sv
// Bench for sda_gmem_axi_slave: word-memory model, B/R expected queues popped by
// negedge monitors, and directed bursts covering strobes, errors, backpressure and reset.
module tb_sda_gmem_axi_slave;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [63:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]  s_axi_awlen, s_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_arsize;
    logic [1:0]  s_axi_awburst, s_axi_arburst;
    logic        s_axi_awid, s_axi_arid;
    logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bid, s_axi_bvalid, s_axi_bready;
    logic        s_axi_rlast, s_axi_rid, s_axi_rvalid, s_axi_rready;
    logic [1:0]  o_dbg_wstate, o_dbg_rstate;

    sda_gmem_axi_slave dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awid(s_axi_awid),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arid(s_axi_arid),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rid(s_axi_rid), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .o_dbg_wstate(o_dbg_wstate), .o_dbg_rstate(o_dbg_rstate)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errs   = 0;
    logic [31:0] model [1024];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [2:0]  exp_b_q[$];   // {bresp, bid}
    logic [35:0] exp_r_q[$];   // {rresp, rlast, rid, rdata}
    int r_beats = 0;
    logic [2:0]  mon_b;
    logic [35:0] mon_r;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic legal(input logic [63:0] addr, input logic [2:0] size,
                                   input logic [1:0] burst);
        return (burst == 2'b01) && (size == 3'b010) && (addr[63:12] == 52'd0);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    mon_b = exp_b_q.pop_front();
                    check("bresp", s_axi_bresp, mon_b[2:1]);
                    check("bid", s_axi_bid, mon_b[0]);
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                r_beats++;
                if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    mon_r = exp_r_q.pop_front();
                    check("rdata", s_axi_rdata, mon_r[31:0]);
                    check("rresp", s_axi_rresp, mon_r[35:34]);
                    check("rlast", s_axi_rlast, mon_r[33]);
                    check("rid", s_axi_rid, mon_r[32]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic aw_send(input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic id);
        int t;
        logic hs;
        @(posedge clk); #2;
        s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
        s_axi_awburst = burst; s_axi_awid = id; s_axi_awvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk); hs = s_axi_awready;
            @(posedge clk); #2; t++;
        end while (!hs && t < 200);
        check("aw_accept", hs, 1);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic id,
                           output int hs_cyc);
        int t;
        logic hs;
        @(posedge clk); #2;
        s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size;
        s_axi_arburst = burst; s_axi_arid = id; s_axi_arvalid = 1'b1;
        t = 0;
        hs_cyc = 0;
        do begin
            @(negedge clk); hs = s_axi_arready; hs_cyc = cyc;
            @(posedge clk); #2; t++;
        end while (!hs && t < 200);
        check("ar_accept", hs, 1);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic w_send(input int nb);
        int t;
        logic hs;
        @(posedge clk); #2;
        for (int i = 0; i < nb; i++) begin
            s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
            s_axi_wlast = (i == nb - 1); s_axi_wvalid = 1'b1;
            t = 0;
            do begin
                @(negedge clk); hs = s_axi_wready;
                @(posedge clk); #2; t++;
            end while (!hs && t < 200);
            check("w_accept", hs, 1);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast = 1'b0;
    endtask

    task automatic prep_write(input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic id, input int nb);
        logic lg;
        logic [9:0] idx;
        lg = legal(addr, size, burst);
        if (lg) begin
            for (int i = 0; i < nb; i++) begin
                idx = addr[11:2] + 10'(i);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[idx][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        exp_b_q.push_back({(lg && nb == int'(len) + 1) ? 2'b00 : 2'b10, id});
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic id, input int nb);
        prep_write(addr, len, size, burst, id, nb);
        fork
            aw_send(addr, len, size, burst, id);
            w_send(nb);
        join
    endtask

    task automatic prep_read(input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic id);
        logic lg;
        logic [9:0] idx;
        lg = legal(addr, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            idx = addr[11:2] + 10'(i);
            exp_r_q.push_back({lg ? 2'b00 : 2'b10, i == int'(len), id, lg ? model[idx] : 32'd0});
        end
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic id);
        int hc;
        prep_read(addr, len, size, burst, id);
        ar_send(addr, len, size, burst, id, hc);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && t < 300) begin
            @(negedge clk); t++;
        end
        check({tag, "_b_drain"}, exp_b_q.size(), 0);
        check({tag, "_r_drain"}, exp_r_q.size(), 0);
    endtask

    task automatic fill(input int nb, input logic [31:0] base);
        for (int i = 0; i < nb; i++) begin
            wd[i] = base + 32'(i) * 32'h0101_0101;
            ws[i] = 4'hF;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hc, t, base;
        logic [31:0] old0;
        s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awid = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wlast = 0; s_axi_wvalid = 0; s_axi_bready = 1;
        s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
        s_axi_arid = '0; s_axi_arvalid = 0; s_axi_rready = 1;

        repeat (3) @(negedge clk);
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rlast", s_axi_rlast, 0);
        check("rst_bresp", s_axi_bresp, 0);
        check("rst_rresp", s_axi_rresp, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_bid_rid", {s_axi_bid, s_axi_rid}, 0);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("awready_at_release", s_axi_awready, 0);
        @(negedge clk);
        check("awready_after_release", s_axi_awready, 1);
        check("arready_after_release", s_axi_arready, 1);

        // single write then read, with latency checks
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(64'h40, 8'd0, 3'b010, 2'b01, 1'b0, 1);
        @(negedge clk);
        check("b_latency", s_axi_bvalid, 1);
        wait_drain("single_w");
        prep_read(64'h40, 8'd0, 3'b010, 2'b01, 1'b0);
        ar_send(64'h40, 8'd0, 3'b010, 2'b01, 1'b0, hc);
        do @(negedge clk); while (!s_axi_rvalid && cyc - hc < 20);
        check("r_latency", cyc - hc, 2);
        wait_drain("single_r");

        // burst with a partial strobe over a known old word
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        do_write(64'h108, 8'd0, 3'b010, 2'b01, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'h1111_1111 * 32'(i + 1);
            ws[i] = (i == 2) ? 4'b0011 : 4'hF;
        end
        do_write(64'h100, 8'd3, 3'b010, 2'b01, 1'b1, 4);
        do_read(64'h100, 8'd3, 3'b010, 2'b01, 1'b1);
        wait_drain("strobe");

        // B backpressure
        @(posedge clk); #2 s_axi_bready = 1'b0;
        fill(4, 32'h5555_0000);
        do_write(64'h180, 8'd3, 3'b010, 2'b01, 1'b0, 4);
        t = 0;
        while (!s_axi_bvalid && t < 50) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        check("b_hold_valid", s_axi_bvalid, 1);
        check("b_hold_resp", s_axi_bresp, exp_b_q.size() > 0 ? exp_b_q[0][2:1] : 2'b11);
        check("aw_blocked_by_b", s_axi_awready, 0);
        @(posedge clk); #2 s_axi_bready = 1'b1;
        @(negedge clk);
        check("aw_before_b_hs", s_axi_awready, 0);
        @(negedge clk);
        check("aw_after_b_hs", s_axi_awready, 1);
        wait_drain("bp_b");

        // R backpressure mid-burst
        base = r_beats;
        prep_read(64'h180, 8'd3, 3'b010, 2'b01, 1'b1);
        fork
            ar_send(64'h180, 8'd3, 3'b010, 2'b01, 1'b1, hc);
            begin
                t = 0;
                while (r_beats < base + 1 && t < 50) begin @(negedge clk); t++; end
                @(posedge clk); #2 s_axi_rready = 1'b0;
                t = 0;
                do begin @(negedge clk); t++; end while (!s_axi_rvalid && t < 50);
                repeat (2) @(negedge clk);
                check("r_hold_valid", s_axi_rvalid, 1);
                check("r_hold_data", s_axi_rdata, exp_r_q.size() > 0 ? exp_r_q[0][31:0] : 32'hX);
                @(posedge clk); #2 s_axi_rready = 1'b1;
            end
        join
        wait_drain("bp_r");
        check("bp_r_beats", r_beats - base, 4);

        // out-of-range write leaves memory untouched
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        do_write(64'h0, 8'd0, 3'b010, 2'b01, 1'b0, 1);
        wd[0] = 32'hBAD0_BAD0;
        do_write(64'h1_0000_0000, 8'd0, 3'b010, 2'b01, 1'b1, 1);
        do_read(64'h0, 8'd0, 3'b010, 2'b01, 1'b0);
        wait_drain("range");

        // illegal read size, then early wlast
        do_read(64'h40, 8'd1, 3'b011, 2'b01, 1'b1);
        wait_drain("bad_size");
        fill(4, 32'h7700_0011);
        do_write(64'h280, 8'd3, 3'b010, 2'b01, 1'b1, 2);
        do_read(64'h280, 8'd1, 3'b010, 2'b01, 1'b0);
        wait_drain("early_wlast");

        // same-cycle write and read of the same burst: first beat is pre-write data
        fill(4, 32'hA0A0_0000);
        do_write(64'h200, 8'd3, 3'b010, 2'b01, 1'b0, 4);
        wait_drain("pre_conc");
        old0 = model[10'h80];
        fill(4, 32'hB0B0_0000);
        prep_write(64'h200, 8'd3, 3'b010, 2'b01, 1'b1, 4);
        for (int i = 0; i < 4; i++)
            exp_r_q.push_back({2'b00, i == 3, 1'b0, (i == 0) ? old0 : model[10'h80 + 10'(i)]});
        fork
            aw_send(64'h200, 8'd3, 3'b010, 2'b01, 1'b1);
            w_send(4);
            ar_send(64'h200, 8'd3, 3'b010, 2'b01, 1'b0, hc);
        join
        wait_drain("conc");
        do_read(64'h200, 8'd0, 3'b010, 2'b01, 1'b1);
        wait_drain("post_conc");

        // reset in the middle of a read burst
        fill(8, 32'hC0C0_0000);
        do_write(64'h300, 8'd7, 3'b010, 2'b01, 1'b0, 8);
        wait_drain("pre_rst");
        base = r_beats;
        prep_read(64'h300, 8'd7, 3'b010, 2'b01, 1'b1);
        ar_send(64'h300, 8'd7, 3'b010, 2'b01, 1'b1, hc);
        t = 0;
        while (r_beats < base + 2 && t < 50) begin @(negedge clk); t++; end
        t = 0;
        do begin @(negedge clk); t++; end while (!s_axi_rvalid && t < 50);
        #1 reset = 1'b1;
        exp_r_q.delete();
        #1;
        check("midrst_rvalid", s_axi_rvalid, 0);
        check("midrst_arready", s_axi_arready, 0);
        @(posedge clk);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("arready_at_rerelease", s_axi_arready, 0);
        @(negedge clk);
        check("arready_after_rerelease", s_axi_arready, 1);
        do_read(64'h300, 8'd7, 3'b010, 2'b01, 1'b0);
        wait_drain("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errs, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/sda_gmem_axi_slave.md
Name: sda_gmem_axi_slave

Overview:
- AXI4 slave responder for the kernel's global-memory master port (the gmem interface driven by the action core).
- Block-RAM backed word memory.
- Used as the far end of gmem in standalone simulation and on-chip loopback tests, so kernels can run without the SDAccel shell.
- Supports INCR bursts with one outstanding write transaction and one outstanding read transaction, on independent channels.

Parameters:
- ADDR_WIDTH, 64, AWADDR/ARADDR width.
- DATA_WIDTH, 32, data width; fixed at 32 for this block.
- ID_WIDTH, 1, AWID/ARID/BID/RID width.
- MEM_ADDR_WIDTH, 10, log2 of memory depth in 32-bit words.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address
- s_axi_awlen  in  8  beats minus one
- s_axi_awsize  in  3  beat size; only 3'b010 is legal
- s_axi_awburst  in  2  burst type; only INCR (2'b01) is legal
- s_axi_awid  in  ID_WIDTH  write transaction ID
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bid  out  ID_WIDTH  echoed AWID
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arid  in  as AW  read address channel
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rlast  out  1  last read beat
- s_axi_rid  out  ID_WIDTH  echoed ARID
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous, active-high.
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0. bresp, rresp, bid, rid, rdata = 0. Memory contents are not reset.
- Ready after reset: awready and arready are registered and rise to 1 the first clk edge after reset deasserts.
- Reset mid-burst: all FSMs return to IDLE immediately. Partial writes already committed remain in memory.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1. On AW handshake, latch addr, len, id and a legality flag, then go to W_DATA. awready drops the next cycle.
- Legality: legal means awburst==INCR, awsize==3'b010, and address bits [ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] are all zero.
- W_DATA: wready=1.
  - Each W handshake writes the bytes enabled by wstrb to mem[addr[MEM_ADDR_WIDTH+1:2]], but only if the burst is legal.
  - The address then increments by 4.
  - Word index wraps modulo depth with no error; the range check applies to the start address only.
  - A beat counter counts accepted beats.
- Burst end: the burst ends on the beat where wlast=1 or the count equals len, whichever comes first.
  - Error flag is set if wlast and count==len disagree.
  - Go to W_RESP; wready drops the next cycle.
- W_RESP: bvalid=1, bid=latched id. bresp = 2'b00 if the burst was legal and had no error, else 2'b10 (SLVERR). Hold until bready, then go to W_IDLE.
- Write latency: bvalid rises the cycle after the last W handshake.

Read FSM (R_IDLE, R_FETCH, R_DATA):
- R_IDLE: arready=1. On AR handshake, latch addr, len, id and legality (same rules as write), then go to R_FETCH.
- R_FETCH: registered memory read into rdata (0 if illegal). Go to R_DATA.
- R_DATA: rvalid=1; rid=id; rresp=00 or 10; rlast=1 when beat count==len. rdata is held stable while rvalid && !rready.
  - On R handshake: if last beat, go to R_IDLE; otherwise increment the address and go to R_FETCH.
- Read latency: first rvalid appears 2 cycles after the AR handshake. Sustained rate is one beat per 2 cycles.

Channel independence and collisions:
- Read and write FSMs run independently.
- A write commit and a read fetch to the same word in the same cycle return the old data (read-first).

Test Plan:
- Single write/read: AW addr 0x40 len 0, W 0xDEADBEEF strb F; then AR 0x40 len 0 -> BRESP 00; RDATA 0xDEADBEEF, RLAST 1, RVALID 2 cycles after AR.
- Burst with strobes: AW 0x100 len 3, beats 0x11111111..0x44444444, beat 2 strb 4'b0011; read back len 3 -> 0x11111111, 0x22222222, mem-old[31:16]|0x3333, 0x44444444; RLAST only on beat 4.
- Backpressure: hold BREADY=0 for 5 cycles and RREADY=0 for 3 cycles mid-burst -> BVALID/RDATA stable, no beat lost or duplicated, next AWREADY only after the B handshake.
- Errors:
  - AW addr 0x1_0000_0000 -> BRESP 10, memory unchanged.
  - AR awsize=3'b011 -> every beat RRESP 10, RDATA 0.
  - WLAST on beat 2 of len 3 -> BRESP 10.
- Concurrency: write burst to 0x200 and read burst from 0x200 issued the same cycle -> the first read beat returns pre-write data, both complete with the correct IDs (awid 1, arid 0).
- Reset mid-read-burst at beat 2 of len 7 -> RVALID 0 immediately; ARREADY 1 one cycle after release; a new read returns correct data.
